// File: rtl/stream_ctrl_pkg.sv
// Shared types and sizing helpers for the stream delay flow controller.
package stream_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sdc_state_t;

    // Bits needed to count 0..latency beats in flight.
    function automatic int unsigned occ_w(input int unsigned latency);
        return int'($clog2(latency + 1));
    endfunction

endpackage

// File: rtl/sideband_pipe.sv
// Clock-enabled shift register carrying a valid bit (bit 0, reset) and an unreset payload.
module sideband_pipe #(
    parameter int unsigned N     = 4,
    parameter int unsigned DELAY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [DELAY-1:0] vld;
    logic [N-2:0]     dat [DELAY];

    // Valid bits: cleared by reset so in-flight beats are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (ce) begin
            vld[0] <= d[0];
            for (int i = 1; i < int'(DELAY); i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Payload stages follow the datapath and need no reset.
    always_ff @(posedge clk) begin
        if (ce) begin
            dat[0] <= d[N-1:1];
            for (int i = 1; i < int'(DELAY); i++) begin
                dat[i] <= dat[i-1];
            end
        end
    end

    assign q = {dat[DELAY-1], vld[DELAY-1]};

endmodule

// File: rtl/stream_delay_ctrl.sv
// Flow controller for a fixed-latency clock-enabled datapath: generates ce, aligns
// valid/user/last with the data, applies backpressure and drains when en drops.
module stream_delay_ctrl
    import stream_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned USER_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [USER_W-1:0]          in_user,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [USER_W-1:0]          out_user,
    output logic                       out_last,
    output logic                       ce,
    output logic                       busy,
    output logic [occ_w(LATENCY)-1:0]  occupancy,
    output logic                       drain_done
);

    localparam int unsigned OCC_W = occ_w(LATENCY);
    localparam int unsigned SB_W  = USER_W + 2;

    if (LATENCY < 1) begin : g_bad_latency
        $error("stream_delay_ctrl: LATENCY must be >= 1");
    end

    sdc_state_t       state;
    sdc_state_t       state_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic             drain_done_nxt;
    logic             stall;
    logic             acc;
    logic             take;
    logic [SB_W-1:0]  pipe_q;

    // Handshake and stage enable; stalls only when a valid beat is refused.
    assign stall    = out_valid & ~out_ready;
    assign ce       = (state != IDLE) & ~stall;
    assign in_ready = (state == RUN) & ce;
    assign acc      = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign busy     = (state != IDLE);
    assign occ_nxt  = occupancy + OCC_W'(acc) - OCC_W'(take);

    sideband_pipe #(
        .N     (SB_W),
        .DELAY (LATENCY)
    ) u_sideband_pipe (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   ({in_last, in_user, acc}),
        .q   (pipe_q)
    );

    assign out_valid = pipe_q[0];
    assign out_user  = pipe_q[USER_W:1];
    assign out_last  = pipe_q[USER_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            occupancy  <= '0;
            drain_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            occupancy  <= occ_nxt;
            drain_done <= drain_done_nxt;
        end
    end

    // Next-state uses the post-update occupancy so a beat accepted as en falls still drains.
    always_comb begin
        state_nxt      = state;
        drain_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = (occ_nxt == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_nxt = RUN;
                end else if (occ_nxt == '0) begin
                    state_nxt      = IDLE;
                    drain_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_delay_ctrl.sv
// Directed bench for stream_delay_ctrl (LATENCY=4, USER_W=2) with an in-order beat scoreboard.
module tb_stream_delay_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_user;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_user;
    logic       out_last;
    logic       ce;
    logic       busy;
    logic [2:0] occupancy;
    logic       drain_done;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_out    = 0;
    int         base;
    int         sent;
    int         got;
    int         last_cnt;
    int         last_pos;
    int         dd_cnt;
    logic [2:0] exp_q [$];

    always #5 clk = ~clk;

    stream_delay_ctrl #(
        .LATENCY (4),
        .USER_W  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_user    (in_user),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_user   (out_user),
        .out_last   (out_last),
        .ce         (ce),
        .busy       (busy),
        .occupancy  (occupancy),
        .drain_done (drain_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard bookkeeping on the sampled handshake, then move to just after the next edge.
    task automatic adv();
        logic [31:0] want;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back({in_last, in_user});
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
                else                  want = 32'hDEAD;
                check("sb_beat", 32'({out_last, out_user}), want);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] occ_t1 [12];
        occ_t1 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_user = 2'b00; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        adv();

        // 1: free-flowing stream of 6 beats
        en = 1'b1;
        #4;
        check("t1_idle_ready", 32'(in_ready), 32'd0);
        adv();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 6);
            in_user  = (c == 0) ? 2'b01 : 2'b00;
            #4;
            check($sformatf("t1_ready_c%0d", c), 32'(in_ready), 32'd1);
            check($sformatf("t1_ce_c%0d", c), 32'(ce), 32'd1);
            check($sformatf("t1_vld_c%0d", c), 32'(out_valid), 32'((c >= 4) && (c <= 9)));
            check($sformatf("t1_occ_c%0d", c), 32'(occupancy), 32'(occ_t1[c]));
            if (c >= 4 && c <= 9)
                check($sformatf("t1_user_c%0d", c), 32'(out_user), (c == 4) ? 32'd1 : 32'd0);
            adv();
        end
        in_valid = 1'b0;

        // 2: fill the pipe, stall 3 cycles, then release
        base = n_out; sent = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid  = (sent < 6);
            in_user   = 2'(sent + 1);
            out_ready = (c > 6);
            #4;
            if (c >= 4 && c <= 6) begin
                check($sformatf("t2_ce_c%0d", c), 32'(ce), 32'd0);
                check($sformatf("t2_ready_c%0d", c), 32'(in_ready), 32'd0);
                check($sformatf("t2_vld_c%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("t2_occ_c%0d", c), 32'(occupancy), 32'd4);
                check($sformatf("t2_user_c%0d", c), 32'(out_user), 32'd1);
            end
            if (c == 7) check("t2_resume_ce", 32'(ce), 32'd1);
            if (in_valid && in_ready) sent++;
            adv();
        end
        in_valid = 1'b0;
        check("t2_out_count", 32'(n_out - base), 32'd6);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: en drops as the third beat is accepted, pipe drains
        base = n_out; dd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            in_user  = 2'(c);
            en       = (c < 2);
            #4;
            if (c >= 3 && c <= 6) begin
                check($sformatf("t3_ready_c%0d", c), 32'(in_ready), 32'd0);
                check($sformatf("t3_busy_c%0d", c), 32'(busy), 32'd1);
                check($sformatf("t3_vld_c%0d", c), 32'(out_valid), 32'(c >= 4));
            end
            if (c == 7) begin
                check("t3_done_pulse", 32'(drain_done), 32'd1);
                check("t3_idle_busy", 32'(busy), 32'd0);
            end
            if (drain_done) dd_cnt++;
            adv();
        end
        in_valid = 1'b0;
        check("t3_out_count", 32'(n_out - base), 32'd3);
        check("t3_dd_count", 32'(dd_cnt), 32'd1);

        // 4: re-enable while draining
        en = 1'b1;
        #4;
        adv();
        base = n_out; dd_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 2) || (c == 4) || (c == 5);
            in_user  = (c < 2) ? 2'(3 - c) : 2'(5 - c);
            in_last  = (c == 1);
            en       = (c != 2);
            #4;
            if (c == 3) begin
                check("t4_drain_ready", 32'(in_ready), 32'd0);
                check("t4_drain_busy", 32'(busy), 32'd1);
                check("t4_drain_occ", 32'(occupancy), 32'd2);
            end
            if (c == 4) begin
                check("t4_run_ready", 32'(in_ready), 32'd1);
                check("t4_first_user", 32'(out_user), 32'd3);
            end
            if (c == 8) check("t4_third_user", 32'(out_user), 32'd1);
            if (drain_done) dd_cnt++;
            adv();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("t4_out_count", 32'(n_out - base), 32'd4);
        check("t4_no_done", 32'(dd_cnt), 32'd0);

        // 5: reset with three beats in flight
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            rst      = (c == 3);
            en       = (c < 4);
            #4;
            if (c == 3) check("t5_occ_before", 32'(occupancy), 32'd3);
            if (c == 4) begin
                check("t5_vld", 32'(out_valid), 32'd0);
                check("t5_occ", 32'(occupancy), 32'd0);
                check("t5_busy", 32'(busy), 32'd0);
                check("t5_ce", 32'(ce), 32'd0);
            end
            if (c == 5) check("t5_vld_later", 32'(out_valid), 32'd0);
            adv();
        end
        in_valid = 1'b0; rst = 1'b0;

        // 6: random backpressure, last on the 5th beat
        en = 1'b1;
        #4;
        adv();
        sent = 0; got = 0; last_cnt = 0; last_pos = 0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_user   = 2'(sent);
            in_last   = (sent == 4);
            out_ready = 1'($urandom_range(1, 0));
            #4;
            check("t6_occ_max", 32'(occupancy <= 3'd4), 32'd1);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                got++;
                if (out_last) begin
                    last_cnt++;
                    last_pos = got;
                end
            end
            adv();
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("t6_out_count", 32'(got), 32'd8);
        check("t6_last_count", 32'(last_cnt), 32'd1);
        check("t6_last_pos", 32'(last_pos), 32'd5);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        en = 1'b0;
        for (int cyc = 0; cyc < 20 && busy; cyc++) begin
            #4;
            adv();
        end
        #4;
        check("t6_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
